// File: rtl/mega_alu_wb_if.sv
// Result bus between the ALU stage and the write-back stage, plus the
// register-file write port and architectural SREG driven back upstream.
interface mega_alu_wb_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 16;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rda;
  logic [RW-1:0] in_R;
  logic          in_wide;
  logic          in_rf_we;
  logic [DW-1:0] in_sreg;
  logic          in_sreg_we;
  logic          io_sreg_we;
  logic [DW-1:0] io_sreg_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] sreg;
  logic          done;

  // Upstream side: presents results, observes the write-back stage.
  modport master (
    output in_valid, in_rda, in_R, in_wide, in_rf_we, in_sreg, in_sreg_we,
           io_sreg_we, io_sreg_data,
    input  in_ready, rf_we, rf_addr, rf_data, sreg, done
  );

  // Write-back stage side.
  modport slave (
    input  in_valid, in_rda, in_R, in_wide, in_rf_we, in_sreg, in_sreg_we,
           io_sreg_we, io_sreg_data,
    output in_ready, rf_we, rf_addr, rf_data, sreg, done
  );
endinterface

// File: rtl/mega_alu_wb.sv
// ALU write-back stage: retires one ALU result per transaction as one or two
// register-file byte writes and owns the architectural SREG.
module mega_alu_wb #(
  parameter logic [7:0] SREG_INIT  = 8'h00,
  parameter bit         WIDE_ALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mega_alu_wb_if.slave  bus
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_rf_we, w_rf_we_nxt;
  logic [AW-1:0] r_rf_addr, w_rf_addr_nxt;
  logic [DW-1:0] r_rf_data, w_rf_data_nxt;
  logic          r_done, w_done_nxt;
  logic [DW-1:0] r_sreg, w_sreg_nxt;
  logic [DW-1:0] r_hi, w_hi_nxt;
  logic          r_wide, w_wide_nxt;
  logic          w_accept;

  assign w_accept = bus.in_valid && (r_state == IDLE);

  // Next-state and next-output decode; outputs are registered one edge later.
  always_comb begin
    w_state_nxt   = r_state;
    w_rf_we_nxt   = 1'b0;
    w_rf_addr_nxt = r_rf_addr;
    w_rf_data_nxt = r_rf_data;
    w_done_nxt    = 1'b0;
    w_hi_nxt      = r_hi;
    w_wide_nxt    = r_wide;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_hi_nxt   = bus.in_R[15:8];
          w_wide_nxt = bus.in_wide;
          if (bus.in_rf_we) begin
            w_state_nxt   = WR_LO;
            w_rf_we_nxt   = 1'b1;
            w_rf_addr_nxt = (bus.in_wide && WIDE_ALIGN) ? {bus.in_rda[4:1], 1'b0}
                                                       : bus.in_rda;
            w_rf_data_nxt = bus.in_R[7:0];
            w_done_nxt    = !bus.in_wide;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      WR_LO: begin
        if (r_wide) begin
          w_state_nxt   = WR_HI;
          w_rf_we_nxt   = 1'b1;
          w_rf_addr_nxt = AW'(r_rf_addr + AW'(1));
          w_rf_data_nxt = r_hi;
          w_done_nxt    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR_HI:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  // SREG: a direct I/O write overrides a simultaneous ALU flag commit.
  always_comb begin
    w_sreg_nxt = r_sreg;
    if (bus.io_sreg_we) begin
      w_sreg_nxt = bus.io_sreg_data;
    end else if (w_accept && bus.in_sreg_we) begin
      w_sreg_nxt = bus.in_sreg;
    end
  end

  // State and output registers; reset drops any pending byte write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
      r_done    <= 1'b0;
      r_sreg    <= SREG_INIT;
      r_hi      <= '0;
      r_wide    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= w_ready_nxt;
      r_rf_we   <= w_rf_we_nxt;
      r_rf_addr <= w_rf_addr_nxt;
      r_rf_data <= w_rf_data_nxt;
      r_done    <= w_done_nxt;
      r_sreg    <= w_sreg_nxt;
      r_hi      <= w_hi_nxt;
      r_wide    <= w_wide_nxt;
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_addr  = r_rf_addr;
  assign bus.rf_data  = r_rf_data;
  assign bus.done     = r_done;
  assign bus.sreg     = r_sreg;
endmodule

// File: tb/tb_mega_alu_wb.sv
// Directed bench for mega_alu_wb: vector table for single transactions plus
// hand sequences for SREG override during a write, address wrap and reset abort.
module tb_mega_alu_wb;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  mega_alu_wb_if b0 ();
  mega_alu_wb_if b1 ();

  mega_alu_wb #(.SREG_INIT(8'h00), .WIDE_ALIGN(1'b1)) u_dut  (.clk(clk), .rst(rst), .bus(b0));
  mega_alu_wb #(.SREG_INIT(8'h5A), .WIDE_ALIGN(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rda;
    logic [15:0] r;
    logic        wide;
    logic        rf_we;
    logic [7:0]  sreg_in;
    logic        sreg_we;
    logic        io_we;
    logic [7:0]  io_data;
    logic [4:0]  lo_addr;
    logic [7:0]  lo_data;
    logic [4:0]  hi_addr;
    logic [7:0]  hi_data;
    logic [7:0]  exp_sreg;
  } vec_t;

  vec_t       vecs[7];
  logic [4:0] last_addr;
  logic [7:0] last_data;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    b0.in_valid = 1'b0; b0.in_rda = '0; b0.in_R = '0; b0.in_wide = 1'b0; b0.in_rf_we = 1'b0;
    b0.in_sreg = '0; b0.in_sreg_we = 1'b0; b0.io_sreg_we = 1'b0; b0.io_sreg_data = '0;
    b1.in_valid = 1'b0; b1.in_rda = '0; b1.in_R = '0; b1.in_wide = 1'b0; b1.in_rf_we = 1'b0;
    b1.in_sreg = '0; b1.in_sreg_we = 1'b0; b1.io_sreg_we = 1'b0; b1.io_sreg_data = '0;

    //             rda    R         wide  rfwe  sreg_in sw    iow   io_d    lo_a   lo_d   hi_a   hi_d   sreg
    vecs[0] = '{5'd5,  16'h00A7, 1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 5'd5,  8'hA7, 5'd0,  8'h00, 8'h14};
    vecs[1] = '{5'd0,  16'h1234, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 5'd0,  8'h34, 5'd1,  8'h12, 8'h14};
    vecs[2] = '{5'd17, 16'h0000, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 8'h00, 5'd0,  8'h00, 5'd0,  8'h00, 8'h03};
    vecs[3] = '{5'd7,  16'h00FF, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 8'h80, 5'd7,  8'hFF, 5'd0,  8'h00, 8'h80};
    vecs[4] = '{5'd25, 16'hABCD, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 5'd24, 8'hCD, 5'd25, 8'hAB, 8'h55};
    vecs[5] = '{5'd3,  16'h9999, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00, 5'd0,  8'h00, 5'd0,  8'h00, 8'h55};
    vecs[6] = '{5'd31, 16'h1F42, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 5'd31, 8'h42, 5'd0,  8'h00, 8'h55};

    // Reset state while rst is held.
    step();
    step();
    chk("rst_rf_we",   16'(b0.rf_we),    16'd0);
    chk("rst_done",    16'(b0.done),     16'd0);
    chk("rst_addr",    16'(b0.rf_addr),  16'd0);
    chk("rst_data",    16'(b0.rf_data),  16'd0);
    chk("rst_sreg",    16'(b0.sreg),     16'h00);
    chk("rst_ready",   16'(b0.in_ready), 16'd1);
    chk("rst_sreg_u1", 16'(b1.sreg),     16'h5A);
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;

    // Table: first vector is accepted on the first edge after reset release.
    for (int i = 0; i < 7; i++) begin
      chk("ready_pre", 16'(b0.in_ready), 16'd1);
      b0.in_valid = 1'b1;  b0.in_rda = vecs[i].rda; b0.in_R = vecs[i].r;
      b0.in_wide = vecs[i].wide; b0.in_rf_we = vecs[i].rf_we;
      b0.in_sreg = vecs[i].sreg_in; b0.in_sreg_we = vecs[i].sreg_we;
      b0.io_sreg_we = vecs[i].io_we; b0.io_sreg_data = vecs[i].io_data;
      step();
      b0.in_valid = 1'b0; b0.io_sreg_we = 1'b0;
      chk("sreg", 16'(b0.sreg), 16'(vecs[i].exp_sreg));
      if (vecs[i].rf_we) begin
        chk("lo_we",    16'(b0.rf_we),    16'd1);
        chk("lo_addr",  16'(b0.rf_addr),  16'(vecs[i].lo_addr));
        chk("lo_data",  16'(b0.rf_data),  16'(vecs[i].lo_data));
        chk("lo_done",  16'(b0.done),     16'(!vecs[i].wide));
        chk("lo_ready", 16'(b0.in_ready), 16'd0);
        last_addr = vecs[i].lo_addr;
        last_data = vecs[i].lo_data;
        if (vecs[i].wide) begin
          step();
          chk("hi_we",    16'(b0.rf_we),    16'd1);
          chk("hi_addr",  16'(b0.rf_addr),  16'(vecs[i].hi_addr));
          chk("hi_data",  16'(b0.rf_data),  16'(vecs[i].hi_data));
          chk("hi_done",  16'(b0.done),     16'd1);
          chk("hi_ready", 16'(b0.in_ready), 16'd0);
          last_addr = vecs[i].hi_addr;
          last_data = vecs[i].hi_data;
        end
        step();
      end
      chk("idle_we",    16'(b0.rf_we),    16'(!vecs[i].rf_we ? 1'b0 : 1'b0));
      chk("idle_done",  16'(b0.done),     16'(!vecs[i].rf_we));
      chk("idle_ready", 16'(b0.in_ready), 16'd1);
      chk("hold_addr",  16'(b0.rf_addr),  16'(last_addr));
      chk("hold_data",  16'(b0.rf_data),  16'(last_data));
    end

    // I/O SREG write during WR_LO; in_valid during WR_LO must be ignored.
    b0.in_valid = 1'b1; b0.in_rda = 5'd10; b0.in_R = 16'h7788; b0.in_wide = 1'b1;
    b0.in_rf_we = 1'b1; b0.in_sreg_we = 1'b0;
    step();
    chk("io_lo_addr", 16'(b0.rf_addr), 16'd10);
    chk("io_lo_data", 16'(b0.rf_data), 16'h88);
    b0.in_rda = 5'd3; b0.in_R = 16'h0099; b0.in_wide = 1'b0; b0.in_sreg = 8'h11;
    b0.in_sreg_we = 1'b1; b0.io_sreg_we = 1'b1; b0.io_sreg_data = 8'h3C;
    step();
    b0.in_valid = 1'b0; b0.io_sreg_we = 1'b0; b0.in_sreg_we = 1'b0;
    chk("io_hi_we",   16'(b0.rf_we),   16'd1);
    chk("io_hi_addr", 16'(b0.rf_addr), 16'd11);
    chk("io_hi_data", 16'(b0.rf_data), 16'h77);
    chk("io_hi_done", 16'(b0.done),    16'd1);
    chk("io_sreg",    16'(b0.sreg),    16'h3C);
    step();
    chk("ign_we",    16'(b0.rf_we),    16'd0);
    chk("ign_done",  16'(b0.done),     16'd0);
    chk("ign_addr",  16'(b0.rf_addr),  16'd11);
    chk("ign_ready", 16'(b0.in_ready), 16'd1);
    step();
    chk("ign_we2",   16'(b0.rf_we),    16'd0);

    // Unaligned wide write wrapping 31 -> 0.
    b1.in_valid = 1'b1; b1.in_rda = 5'd31; b1.in_R = 16'hBEEF; b1.in_wide = 1'b1; b1.in_rf_we = 1'b1;
    step();
    b1.in_valid = 1'b0;
    chk("wrap_lo_we",   16'(b1.rf_we),   16'd1);
    chk("wrap_lo_addr", 16'(b1.rf_addr), 16'd31);
    chk("wrap_lo_data", 16'(b1.rf_data), 16'hEF);
    chk("wrap_lo_done", 16'(b1.done),    16'd0);
    step();
    chk("wrap_hi_we",   16'(b1.rf_we),   16'd1);
    chk("wrap_hi_addr", 16'(b1.rf_addr), 16'd0);
    chk("wrap_hi_data", 16'(b1.rf_data), 16'hBE);
    chk("wrap_hi_done", 16'(b1.done),    16'd1);
    step();
    chk("wrap_end_we",  16'(b1.rf_we),   16'd0);
    chk("wrap_sreg",    16'(b1.sreg),    16'h5A);

    // Reset pulsed during WR_LO of a wide result.
    b0.in_valid = 1'b1; b0.in_rda = 5'd2; b0.in_R = 16'h1111; b0.in_wide = 1'b1;
    b0.in_rf_we = 1'b1; b0.in_sreg = 8'h77; b0.in_sreg_we = 1'b1;
    step();
    b0.in_valid = 1'b0; b0.in_sreg_we = 1'b0;
    chk("ra_lo_we", 16'(b0.rf_we), 16'd1);
    chk("ra_sreg",  16'(b0.sreg),  16'h77);
    #2 rst = 1'b1;
    #1;
    chk("ra_async_we",   16'(b0.rf_we),   16'd0);
    chk("ra_async_sreg", 16'(b0.sreg),    16'h00);
    chk("ra_async_addr", 16'(b0.rf_addr), 16'd0);
    chk("ra_async_done", 16'(b0.done),    16'd0);
    step();
    rst = 1'b0;
    chk("ra_rel_we",    16'(b0.rf_we),    16'd0);
    chk("ra_rel_ready", 16'(b0.in_ready), 16'd1);
    b0.in_valid = 1'b1; b0.in_rda = 5'd9; b0.in_R = 16'h0033; b0.in_wide = 1'b0; b0.in_rf_we = 1'b1;
    step();
    b0.in_valid = 1'b0;
    chk("ra_first_we",   16'(b0.rf_we),   16'd1);
    chk("ra_first_addr", 16'(b0.rf_addr), 16'd9);
    chk("ra_first_data", 16'(b0.rf_data), 16'h33);
    step();
    chk("ra_no_hi_we",   16'(b0.rf_we),   16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mega_alu_wb.md
MEGA_ALU_WB -- requirements
Module: mega_alu_wb

Interface
REQ-001 SHALL have parameter SREG_INIT, default 8'h00, the SREG value loaded on reset.
REQ-002 SHALL have parameter WIDE_ALIGN, default 1, which when 1 forces bit 0 of the low-byte address to 0 for wide writes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an ALU result is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage can accept a result.
REQ-007 SHALL have port in_rda, input, 5 bits: the destination register address.
REQ-008 SHALL have port in_R, input, 16 bits: the ALU result.
REQ-009 SHALL have port in_wide, input, 1 bit: the result is 16-bit (MUL family, MOVW, ADIW, SBIW).
REQ-010 SHALL have port in_rf_we, input, 1 bit: the result is written to the register file (0 for CP, CPC, CPI, BST, SEx/CLx).
REQ-011 SHALL have port in_sreg, input, 8 bits: the ALU sreg_out.
REQ-012 SHALL have port in_sreg_we, input, 1 bit: commit in_sreg.
REQ-013 SHALL have port io_sreg_we, input, 1 bit: direct I/O write to SREG (OUT 0x3F).
REQ-014 SHALL have port io_sreg_data, input, 8 bits: the I/O write data.
REQ-015 SHALL have port rf_we, output, 1 bit: register-file byte write strobe.
REQ-016 SHALL have port rf_addr, output, 5 bits: register-file write address.
REQ-017 SHALL have port rf_data, output, 8 bits: register-file write data.
REQ-018 SHALL have port sreg, output, 8 bits: the architectural SREG, fed back to the ALU sreg_in.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse marking retirement of a result.

Function
REQ-020 SHALL implement states IDLE, WR_LO and WR_HI, with in_ready=1 only in IDLE.
REQ-021 SHALL accept a result on a rising edge where in_valid=1 and in_ready=1, latching in_rda, in_R, in_wide and in_rf_we.
REQ-022 On accept with in_rf_we=1 SHALL go to WR_LO, and on accept with in_rf_we=0 SHALL stay in IDLE and assert done the next cycle.
REQ-023 In WR_LO SHALL drive rf_we=1, rf_data=R[7:0] and rf_addr=rda, or {rda[4:1],1'b0} when the result is wide and WIDE_ALIGN=1.
REQ-024 From WR_LO SHALL go to WR_HI if the result is wide, else to IDLE with done=1 in that WR_LO cycle.
REQ-025 In WR_HI SHALL drive rf_we=1, rf_data=R[15:8] and rf_addr=(WR_LO address)+1 (5-bit, wraps 31->0 when WIDE_ALIGN=0), with done=1, then go to IDLE.
REQ-026 Latency from accept edge to last write SHALL be 1 cycle for narrow results and 2 cycles for wide results.
REQ-027 Sustained throughput SHALL be one narrow result per 2 cycles and one wide result per 3 cycles.
REQ-028 rf_we, rf_addr, rf_data and done SHALL be registered, with rf_we=0 and done=0 outside the cycles defined above.
REQ-029 In IDLE rf_addr and rf_data SHALL hold their last values.
REQ-030 sreg SHALL update at the accept edge when in_sreg_we=1, so the new value is visible one cycle after acceptance, before the low-byte write completes.
REQ-031 io_sreg_we=1 SHALL load io_sreg_data into sreg at the next edge in any state.
REQ-032 When io_sreg_we coincides with an accepted in_sreg_we, io_sreg_data SHALL win.
REQ-033 in_valid while in WR_LO or WR_HI SHALL be ignored; the upstream stage holds its inputs until in_ready=1.
REQ-034 Acceptance with in_sreg_we=0 and in_rf_we=0 SHALL still produce done.

Reset
REQ-035 On rst=1, immediately and asynchronously, the block SHALL enter IDLE with rf_we=0, done=0, rf_addr=0, rf_data=0 and sreg=SREG_INIT.
REQ-036 A reset asserted during WR_LO or WR_HI SHALL abort the pending byte write, with no write issued after reset release.
REQ-037 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-038 The bench SHALL cover: ADD-type narrow result, in_rda=5, in_R=16'h00A7, in_sreg=8'h14, in_sreg_we=1 -> next cycle rf_we=1, rf_addr=5, rf_data=8'hA7, sreg=8'h14, done=1; in_ready=1 one cycle later.
REQ-039 The bench SHALL cover: MUL wide result, in_rda=0, in_R=16'h1234 -> cycle+1 rf_addr=0, rf_data=8'h34; cycle+2 rf_addr=1, rf_data=8'h12, done=1; in_ready=0 during both cycles.
REQ-040 The bench SHALL cover: CP (in_rf_we=0, in_sreg=8'h03) -> no rf_we, sreg=8'h03 and done=1 next cycle.
REQ-041 The bench SHALL cover: accept with in_sreg=8'h02 while io_sreg_we=1 and io_sreg_data=8'h80 on the same edge -> sreg=8'h80.
REQ-042 The bench SHALL cover: wide result with in_rda=31 and WIDE_ALIGN=0 -> writes to addresses 31 then 0.
REQ-043 The bench SHALL cover: rst pulsed during WR_LO of a wide result -> rf_we=0 immediately, sreg=SREG_INIT, no WR_HI write, in_ready=1 after release.
